cipher_lsb_embed: RTL

Downstream consumer of the DES/3DES final-permutation output: accepts 64-bit cipher blocks on a valid/ready handshake and hides them in a pixel byte stream by overwriting the LSB(s) of successive pixels. The block sits between the encryption datapath and the image write-out path of the steganography pipeline. It buffers one pending block behind the one being embedded so back-to-back blocks embed without bubbles.

---
 rtl/cipher_lsb_embed.sv | 117 +++++++++++
 1 files changed

// File: rtl/cipher_lsb_embed.sv
// Hides 64-bit cipher blocks in the LSBs of a pixel stream. One block can wait in a
// pending register while another is being embedded, so consecutive blocks need no bubble.
module cipher_lsb_embed #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned LSB_N = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blk_valid,
  input  logic [1:64]      blk_data,
  output logic             blk_ready,
  input  logic             bypass,
  input  logic             pix_in_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             pix_in_ready,
  output logic             pix_out_valid,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_out_emb,
  input  logic             pix_out_ready,
  output logic             busy,
  output logic [15:0]      blk_count
);

  localparam int unsigned NPix = 64 / LSB_N;
  localparam int unsigned CntW = $clog2(NPix);
  localparam logic [CntW-1:0] CntLast = CntW'(NPix - 1);

  typedef enum logic {StIdle, StEmbed} state_e;

  state_e           state_q;
  logic             pend_v_q;
  logic [63:0]      pend_data_q;
  logic [63:0]      act_data_q;
  logic [CntW-1:0]  cnt_q;
  logic             pix_out_valid_q;
  logic [PIX_W-1:0] pix_out_q;
  logic             pix_out_emb_q;
  logic [15:0]      blk_count_q;

  logic             act_v;
  logic             blk_acc;
  logic             pix_acc;
  logic [LSB_N-1:0] emb_bits;
  logic [PIX_W-1:0] stego_pix;

  assign act_v     = (state_q == StEmbed);
  assign blk_acc   = blk_valid & ~pend_v_q;
  assign pix_acc   = pix_in_valid & pix_in_ready;
  // Bit 63 holds DES bit 1, so the next bits to embed always sit at the top.
  assign emb_bits  = act_data_q[63 -: LSB_N];
  assign stego_pix = {pix_in[PIX_W-1:LSB_N], emb_bits};

  assign blk_ready     = ~pend_v_q;
  assign pix_in_ready  = (~pix_out_valid_q | pix_out_ready) & (act_v | bypass);
  assign pix_out_valid = pix_out_valid_q;
  assign pix_out       = pix_out_q;
  assign pix_out_emb   = pix_out_emb_q;
  assign busy          = act_v | pend_v_q;
  assign blk_count     = blk_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      pend_v_q        <= 1'b0;
      pend_data_q     <= '0;
      act_data_q      <= '0;
      cnt_q           <= '0;
      pix_out_valid_q <= 1'b0;
      pix_out_q       <= '0;
      pix_out_emb_q   <= 1'b0;
      blk_count_q     <= '0;
    end else begin
      if (pix_acc) begin
        pix_out_valid_q <= 1'b1;
        pix_out_q       <= act_v ? stego_pix : pix_in;
        pix_out_emb_q   <= act_v;
      end else if (pix_out_ready) begin
        pix_out_valid_q <= 1'b0;
      end

      // Accept only into an empty pending slot; the loads below only run with it full.
      if (blk_acc) begin
        pend_v_q    <= 1'b1;
        pend_data_q <= blk_data;
      end

      case (state_q)
        StIdle: begin
          if (pend_v_q) begin
            state_q    <= StEmbed;
            act_data_q <= pend_data_q;
            cnt_q      <= '0;
            pend_v_q   <= 1'b0;
          end
        end
        StEmbed: begin
          if (pix_acc) begin
            act_data_q <= act_data_q << LSB_N;
            cnt_q      <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              blk_count_q <= blk_count_q + 16'd1;
              cnt_q       <= '0;
              if (pend_v_q) begin
                act_data_q <= pend_data_q;
                pend_v_q   <= 1'b0;
              end else begin
                state_q <= StIdle;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
